// File: rtl/dma_pkg.sv
// Shared types and default widths for the memory-copy DMA.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } dma_state_e;

  localparam int DEF_ADD_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 16;

endpackage

// File: rtl/dma_addr_counter.sv
// Loadable word-address register that increments by one, wrapping modulo 2^ADD_WIDTH.
module dma_addr_counter
  import dma_pkg::*;
#(
  parameter int ADD_WIDTH = DEF_ADD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [ADD_WIDTH-1:0] load_val_i,
  input  logic                 inc_i,
  output logic [ADD_WIDTH-1:0] addr_o
);

  logic [ADD_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (inc_i) begin
      addr_d = addr_q + ADD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: one READ and one WRITE cycle per word.
// Optional running checksum of copied words when DMA_CHECKSUM_EN is defined.
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADD_WIDTH-1:0]  src_addr,
  input  logic [ADD_WIDTH-1:0]  dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [ADD_WIDTH-1:0]  A,
  output logic                  WE,
  output logic [DATA_WIDTH-1:0] WD,
`ifdef DMA_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  input  logic [DATA_WIDTH-1:0] RD
);

  dma_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  addr_load;
  logic                  addr_inc;
  logic [ADD_WIDTH-1:0]  src_cur;
  logic [ADD_WIDTH-1:0]  dst_cur;

  dma_addr_counter #(.ADD_WIDTH(ADD_WIDTH)) u_src_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (addr_load),
    .load_val_i (src_addr),
    .inc_i      (addr_inc),
    .addr_o     (src_cur)
  );

  dma_addr_counter #(.ADD_WIDTH(ADD_WIDTH)) u_dst_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (addr_load),
    .load_val_i (dst_addr),
    .inc_i      (addr_inc),
    .addr_o     (dst_cur)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
    A         = '0;
    WE        = 1'b0;
    WD        = '0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        // Parameters are only captured here, so a start while busy is ignored.
        if (start) begin
          addr_load = 1'b1;
          cnt_d     = len;
          state_d   = (len != '0) ? READ : FINISH;
        end
      end
      READ: begin
        A       = src_cur;
        buf_d   = RD;
        state_d = WRITE;
      end
      WRITE: begin
        A        = dst_cur;
        WE       = 1'b1;
        WD       = buf_q;
        addr_inc = 1'b1;
        cnt_d    = cnt_q - LEN_WIDTH'(1);
        state_d  = (cnt_q != LEN_WIDTH'(1)) ? READ : FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

`ifdef DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start) begin
      csum_d = '0;
    end else if (state_q == READ) begin
      csum_d = csum_q + RD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed self-checking bench for mem_copy_dma with a small behavioural memory.
module tb_mem_copy_dma;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] A;
  logic          WE;
  logic [DW-1:0] WD;
  logic [DW-1:0] RD;
`ifdef DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] mem [0:255];
  logic          pk_en = 1'b0;
  logic [7:0]    pk_a = '0;
  logic [DW-1:0] pk_d = '0;

  int pass_cnt = 0;
  int total = 0;

  int done_cycle, done_count, we_count, busy_cycles, rd_count;
  logic [AW-1:0] rd_addrs [0:7];
  logic [AW-1:0] wr_addrs [0:7];

  always #5 clk = ~clk;

  assign RD = mem[A[7:0]];

  always @(posedge clk) begin
    if (pk_en) mem[pk_a] <= pk_d;
    else if (WE) mem[A[7:0]] <= WD;
  end

  mem_copy_dma #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .A        (A),
    .WE       (WE),
    .WD       (WD),
`ifdef DMA_CHECKSUM_EN
    .checksum (checksum),
`endif
    .RD       (RD)
  );

  task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_a = a; pk_d = d;
    @(posedge clk);
    #1 pk_en = 1'b0;
  endtask

  task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle c=1 is the first cycle after the accepting edge; repulse fires a stray start.
  task automatic watch(input int repulse);
    bit finished = 0;
    done_cycle = 0; done_count = 0; we_count = 0; busy_cycles = 0; rd_count = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == repulse) begin
        start = 1'b1; src_addr = 32'h30; dst_addr = 32'h50; len = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cycles++;
      if (done) begin done_count++; done_cycle = c; end
      if (WE) begin
        if (we_count < 8) wr_addrs[we_count] = A;
        we_count++;
      end else if (busy && !done) begin
        if (rd_count < 8) rd_addrs[rd_count] = A;
        rd_count++;
      end
      if (!busy) begin finished = 1; break; end
    end
    start = 1'b0;
    total++;
    if (!finished) $display("FAIL watch_timeout: transfer still busy after 60 cycles, required idle");
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, WE} !== 3'b000) $display("FAIL reset_ctrl: busy/done/WE=%b required 000", {busy, done, WE});
    else pass_cnt++;
    total++;
    if (A !== '0) $display("FAIL reset_A: A=%0h required 0", A); else pass_cnt++;
    total++;
    if (WD !== '0) $display("FAIL reset_WD: WD=%0h required 0", WD); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset: busy/done=%b required 00", {busy, done});
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), DW'(i + 1));
    for (int i = 0; i < 4; i++) poke(8'(8'h20 + i), '0);
    launch(32'h10, 32'h20, 16'd4);
    watch(0);
    total++;
    if (done_cycle !== 9) $display("FAIL basic_done_cycle: got %0d required 9", done_cycle); else pass_cnt++;
    total++;
    if (done_count !== 1) $display("FAIL basic_done_count: got %0d required 1", done_count); else pass_cnt++;
    total++;
    if (we_count !== 4) $display("FAIL basic_we_count: got %0d required 4", we_count); else pass_cnt++;
    total++;
    if (busy_cycles !== 9) $display("FAIL basic_busy_cycles: got %0d required 9", busy_cycles); else pass_cnt++;
    total++;
    if (rd_addrs[3] !== 32'h13) $display("FAIL basic_rd_addr3: got %0h required 13", rd_addrs[3]); else pass_cnt++;
    total++;
    if (wr_addrs[0] !== 32'h20) $display("FAIL basic_wr_addr0: got %0h required 20", wr_addrs[0]); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[32 + i] !== DW'(i + 1)) $display("FAIL basic_mem%0d: got %0h required %0h", i, mem[32 + i], i + 1);
      else pass_cnt++;
    end
    $display("test_basic: src=10 dst=20 len=4 done_cycle=%0d writes=%0d", done_cycle, we_count);
  endtask

  task automatic test_zero_len;
    launch(32'h10, 32'h20, 16'd0);
    watch(0);
    total++;
    if (we_count !== 0) $display("FAIL zero_we_count: got %0d required 0", we_count); else pass_cnt++;
    total++;
    if (done_cycle !== 1) $display("FAIL zero_done_cycle: got %0d required 1", done_cycle); else pass_cnt++;
    total++;
    if (busy_cycles !== 1) $display("FAIL zero_busy_cycles: got %0d required 1", busy_cycles); else pass_cnt++;
    $display("test_zero_len: done_cycle=%0d busy_cycles=%0d", done_cycle, busy_cycles);
  endtask

  task automatic test_single;
    poke(8'h70, '0);
    launch(32'h13, 32'h70, 16'd1);
    watch(0);
    total++;
    if (done_cycle !== 3) $display("FAIL single_done_cycle: got %0d required 3", done_cycle); else pass_cnt++;
    total++;
    if (mem[8'h70] !== 32'd4) $display("FAIL single_mem: got %0h required 4", mem[8'h70]); else pass_cnt++;
    $display("test_single: src=13 dst=70 len=1 done_cycle=%0d", done_cycle);
  endtask

  task automatic test_wrap;
    poke(8'hFF, 32'hAAAA);
    poke(8'h00, 32'hBBBB);
    poke(8'h05, '0);
    poke(8'h06, '0);
    launch(32'hFFFF_FFFF, 32'h5, 16'd2);
    watch(0);
    total++;
    if (rd_addrs[0] !== 32'hFFFF_FFFF) $display("FAIL wrap_rd0: got %0h required ffffffff", rd_addrs[0]); else pass_cnt++;
    total++;
    if (rd_addrs[1] !== 32'h0) $display("FAIL wrap_rd1: got %0h required 0", rd_addrs[1]); else pass_cnt++;
    total++;
    if (wr_addrs[0] !== 32'h5 || wr_addrs[1] !== 32'h6)
      $display("FAIL wrap_wr: got %0h,%0h required 5,6", wr_addrs[0], wr_addrs[1]);
    else pass_cnt++;
    total++;
    if (mem[5] !== 32'hAAAA || mem[6] !== 32'hBBBB)
      $display("FAIL wrap_data: got %0h,%0h required aaaa,bbbb", mem[5], mem[6]);
    else pass_cnt++;
    total++;
    if (done_cycle !== 5) $display("FAIL wrap_done_cycle: got %0d required 5", done_cycle); else pass_cnt++;
    $display("test_wrap: reads %0h,%0h writes %0h,%0h", rd_addrs[0], rd_addrs[1], wr_addrs[0], wr_addrs[1]);
  endtask

  task automatic test_ignore_start;
    for (int i = 0; i < 4; i++) poke(8'(8'h40 + i), '0);
    poke(8'h50, 32'hDEAD);
    launch(32'h10, 32'h40, 16'd4);
    watch(3);
    total++;
    if (done_count !== 1 || done_cycle !== 9)
      $display("FAIL ignore_done: count=%0d cycle=%0d required 1,9", done_count, done_cycle);
    else pass_cnt++;
    total++;
    if (wr_addrs[3] !== 32'h43) $display("FAIL ignore_wr_addr3: got %0h required 43", wr_addrs[3]); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[64 + i] !== DW'(i + 1)) $display("FAIL ignore_mem%0d: got %0h required %0h", i, mem[64 + i], i + 1);
      else pass_cnt++;
    end
    total++;
    if (mem[8'h50] !== 32'hDEAD) $display("FAIL ignore_stray_dst: got %0h required dead", mem[8'h50]); else pass_cnt++;
    $display("test_ignore_start: done_cycle=%0d writes=%0d", done_cycle, we_count);
  endtask

  task automatic test_reset_mid;
    int stray_done = 0;
    int stray_busy = 0;
    for (int i = 0; i < 4; i++) poke(8'(8'h60 + i), '0);
    launch(32'h10, 32'h60, 16'd4);
    repeat (4) @(negedge clk);
    total++;
    if (WE !== 1'b1 || A !== 32'h61) $display("FAIL mid_pre_write2: WE=%b A=%0h required 1,61", WE, A); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({WE, busy, done} !== 3'b000) $display("FAIL mid_reset_ctrl: WE/busy/done=%b required 000", {WE, busy, done});
    else pass_cnt++;
    total++;
    if (A !== '0 || WD !== '0) $display("FAIL mid_reset_bus: A=%0h WD=%0h required 0,0", A, WD); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) stray_done++;
      if (busy) stray_busy++;
    end
    total++;
    if (stray_done !== 0 || stray_busy !== 0)
      $display("FAIL mid_no_resume: done=%0d busy=%0d cycles required 0,0", stray_done, stray_busy);
    else pass_cnt++;
    total++;
    if (mem[8'h60] !== 32'd1) $display("FAIL mid_word1: got %0h required 1", mem[8'h60]); else pass_cnt++;
    total++;
    if (mem[8'h61] !== '0 || mem[8'h62] !== '0)
      $display("FAIL mid_later_words: got %0h,%0h required 0,0", mem[8'h61], mem[8'h62]);
    else pass_cnt++;
    $display("test_reset_mid: mem[60..62]=%0h,%0h,%0h", mem[8'h60], mem[8'h61], mem[8'h62]);
  endtask

`ifdef DMA_CHECKSUM_EN
  task automatic test_checksum;
    poke(8'h80, 32'hFFFF_FFFF);
    poke(8'h81, 32'h2);
    launch(32'h80, 32'h90, 16'd2);
    watch(0);
    total++;
    if (checksum !== 32'h1) $display("FAIL csum_after_done: got %0h required 1", checksum); else pass_cnt++;
    repeat (3) @(negedge clk);
    total++;
    if (checksum !== 32'h1) $display("FAIL csum_hold: got %0h required 1", checksum); else pass_cnt++;
    $display("test_checksum: checksum=%0h", checksum);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_single();
    test_wrap();
    test_ignore_start();
    test_reset_mid();
`ifdef DMA_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
